// File: rtl/gpu_cmd_pkg.sv
// gpu_cmd_pkg: shared types and field layout for the GPU command queue.
//   - opcode_e : opcode field of a non-sprite instruction word
//   - cmd_op_e : encoding driven on cmd_op toward the rasterizer
//   - cmd_t    : registered command payload presented to the rasterizer
//   - entry_t  : one FIFO entry, {sprite flag, instruction word}
//   - state_e  : issue FSM states
// No ports (package).
package gpu_cmd_pkg;

    localparam int WORD_W  = 32;
    localparam int ENTRY_W = WORD_W + 1;

    // Opcode word layout (sprite = 0)
    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 28;
    localparam int COLOR_MSB = 7;
    localparam int COLOR_LSB = 0;

    // Sprite word layout (sprite = 1)
    localparam int SPR_ID_MSB = 31;
    localparam int SPR_ID_LSB = 24;
    localparam int SPR_X_MSB  = 23;
    localparam int SPR_X_LSB  = 14;
    localparam int SPR_Y_MSB  = 13;
    localparam int SPR_Y_LSB  = 5;
    localparam int SPR_F_MSB  = 4;
    localparam int SPR_F_LSB  = 0;

    typedef enum logic [3:0] {
        OPC_NOP   = 4'd0,
        OPC_CLEAR = 4'd1,
        OPC_SWAP  = 4'd2
    } opcode_e;

    typedef enum logic [1:0] {
        CMD_SPRITE = 2'd0,
        CMD_CLEAR  = 2'd1
    } cmd_op_e;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] sprite_id;
        logic [9:0] x;
        logic [8:0] y;
        logic [4:0] flags;
        logic [7:0] color;
    } cmd_t;

    typedef struct packed {
        logic              sprite;
        logic [WORD_W-1:0] word;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_VS
    } state_e;

endpackage

// File: rtl/gpu_cmd_queue_if.sv
// gpu_cmd_queue_if: valid/ready command bus from the queue to the rasterizer.
//   cmd_valid     queue -> rasterizer  command valid
//   cmd_ready     rasterizer -> queue  command accepted
//   cmd_op        2   0 SPRITE, 1 CLEAR
//   cmd_sprite_id 8   sprite index
//   cmd_x         10  x position
//   cmd_y         9   y position
//   cmd_flags     5   sprite flags
//   cmd_color     8   clear colour
// Modports: master (queue side), slave (rasterizer side).
interface gpu_cmd_queue_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_sprite_id;
    logic [9:0] cmd_x;
    logic [8:0] cmd_y;
    logic [4:0] cmd_flags;
    logic [7:0] cmd_color;

    modport master (
        output cmd_valid, cmd_op, cmd_sprite_id, cmd_x, cmd_y, cmd_flags, cmd_color,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_sprite_id, cmd_x, cmd_y, cmd_flags, cmd_color,
        output cmd_ready
    );

endinterface

// File: rtl/gpu_cmd_fifo.sv
// gpu_cmd_fifo: synchronous FIFO, DEPTH x WIDTH, with a registered head output.
//   clk, rst  clock, synchronous active-high reset
//   push, din write request / data; dropped when full unless a pop happens too
//   pop       read request; ignored when empty
//   dout      registered head entry (valid whenever !empty)
//   empty     no entries stored
//   accept    this cycle's push is being written
//   count     current occupancy, 0..DEPTH
module gpu_cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 33
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic                   accept,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_n;
    logic             pop_ok;
    logic             head_from_din;

    assign empty    = (count == '0);
    assign pop_ok   = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign accept   = push & ((count != DEPTH_C) | pop_ok);
    assign rd_ptr_n = rd_ptr + AW'(pop_ok);
    // The incoming word becomes the head when nothing older survives this edge.
    assign head_from_din = accept & (count == CW'(pop_ok));

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_ptr_n;
            count  <= count + CW'(accept) - CW'(pop_ok);
            if (head_from_din)
                dout <= din;
            else if (pop_ok)
                dout <= mem[rd_ptr_n];
        end
    end

endmodule

// File: rtl/gpu_cmd_queue.sv
// gpu_cmd_queue: captures PIO instruction words into a FIFO, decodes them and
// issues sprite/clear commands to the rasterizer; SWAP waits for the next
// vsync frame-start edge and then pulses frame_swap.
//   clk_clk, reset_reset  clock, synchronous active-high reset
//   gpu_instruction[31:0] instruction word
//   gpu_run               each 0->1 transition pushes one entry
//   gpu_sprite            1: sprite draw word, 0: opcode word
//   gpu_ready             registered, 1 = next push will be accepted
//   vga_vsync             vsync, polarity set by VSYNC_ACT_LOW
//   cmd                   command bus (gpu_cmd_queue_if.master)
//   frame_swap            one-cycle framebuffer swap pulse
//   fifo_count            FIFO occupancy
// Optional macro GPU_CMD_STATS_EN adds stat_cmds, stat_frames, stat_overflow.
module gpu_cmd_queue
    import gpu_cmd_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter bit VSYNC_ACT_LOW = 1'b1
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    input  logic [WORD_W-1:0]      gpu_instruction,
    input  logic                   gpu_run,
    input  logic                   gpu_sprite,
    output logic                   gpu_ready,
    input  logic                   vga_vsync,
    gpu_cmd_queue_if.master        cmd,
    output logic                   frame_swap,
`ifdef GPU_CMD_STATS_EN
    output logic [15:0]            stat_cmds,
    output logic [15:0]            stat_frames,
    output logic                   stat_overflow,
`endif
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic               run_q;
    logic               run_edge;
    logic               vs_q;
    logic               vs_edge;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               fifo_empty;
    logic               fifo_accept;
    logic               pop;
    logic [CW-1:0]      count_nxt;
    entry_t             head;

    state_e             state, state_n;
    cmd_t               out_q, out_n;
    logic               valid_q, valid_n;
    logic               swap_n;

    assign run_edge = gpu_run & ~run_q;
    assign vs_edge  = VSYNC_ACT_LOW ? (vs_q & ~vga_vsync) : (~vs_q & vga_vsync);

    gpu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk    (clk_clk),
        .rst    (reset_reset),
        .push   (run_edge),
        .din    ({gpu_sprite, gpu_instruction}),
        .pop    (pop),
        .dout   (fifo_dout),
        .empty  (fifo_empty),
        .accept (fifo_accept),
        .count  (fifo_count)
    );

    assign head      = entry_t'(fifo_dout);
    // pop is only raised on a non-empty FIFO, so it always takes effect.
    assign count_nxt = fifo_count + CW'(fifo_accept) - CW'(pop);

    always_comb begin
        state_n = state;
        out_n   = out_q;
        valid_n = valid_q;
        swap_n  = 1'b0;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head.sprite) begin
                        out_n.op        = CMD_SPRITE;
                        out_n.sprite_id = head.word[SPR_ID_MSB:SPR_ID_LSB];
                        out_n.x         = head.word[SPR_X_MSB:SPR_X_LSB];
                        out_n.y         = head.word[SPR_Y_MSB:SPR_Y_LSB];
                        out_n.flags     = head.word[SPR_F_MSB:SPR_F_LSB];
                        valid_n         = 1'b1;
                        state_n         = S_ISSUE;
                    end else begin
                        case (head.word[OPC_MSB:OPC_LSB])
                            OPC_CLEAR: begin
                                out_n.op    = CMD_CLEAR;
                                out_n.color = head.word[COLOR_MSB:COLOR_LSB];
                                valid_n     = 1'b1;
                                state_n     = S_ISSUE;
                            end
                            OPC_SWAP: state_n = S_WAIT_VS;
                            default:  ; // NOP and unassigned opcodes are consumed silently
                        endcase
                    end
                end
            end
            S_ISSUE: begin
                if (cmd.cmd_ready) begin
                    valid_n = 1'b0;
                    state_n = S_IDLE;
                end
            end
            S_WAIT_VS: begin
                // vs_edge was already visible while in IDLE during the pop
                // cycle, so an edge there never reaches this branch.
                if (vs_edge) begin
                    swap_n  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state      <= S_IDLE;
            out_q      <= '0;
            valid_q    <= 1'b0;
            frame_swap <= 1'b0;
            run_q      <= 1'b0;
            vs_q       <= VSYNC_ACT_LOW;
            gpu_ready  <= 1'b0;
        end else begin
            state      <= state_n;
            out_q      <= out_n;
            valid_q    <= valid_n;
            frame_swap <= swap_n;
            run_q      <= gpu_run;
            vs_q       <= vga_vsync;
            gpu_ready  <= (count_nxt < DEPTH_C);
        end
    end

    assign cmd.cmd_valid     = valid_q;
    assign cmd.cmd_op        = out_q.op;
    assign cmd.cmd_sprite_id = out_q.sprite_id;
    assign cmd.cmd_x         = out_q.x;
    assign cmd.cmd_y         = out_q.y;
    assign cmd.cmd_flags     = out_q.flags;
    assign cmd.cmd_color     = out_q.color;

`ifdef GPU_CMD_STATS_EN
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            stat_cmds     <= '0;
            stat_frames   <= '0;
            stat_overflow <= 1'b0;
        end else begin
            if (valid_q && cmd.cmd_ready) stat_cmds <= stat_cmds + 16'd1;
            if (swap_n)                   stat_frames <= stat_frames + 16'd1;
            if (run_edge && !fifo_accept) stat_overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// tb_gpu_cmd_queue: directed scenarios plus randomized traffic against a
// transaction-level model of the command stream.
module tb_gpu_cmd_queue;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        run = 1'b0;
    logic        spr = 1'b0;
    logic        vsync = 1'b1;
    logic        gpu_ready;
    logic        frame_swap;
    logic [4:0]  fifo_count;
`ifdef GPU_CMD_STATS_EN
    logic [15:0] stat_cmds;
    logic [15:0] stat_frames;
    logic        stat_overflow;
`endif

    gpu_cmd_queue_if cmd_if ();

    gpu_cmd_queue #(.DEPTH(DEPTH), .VSYNC_ACT_LOW(1'b1)) dut (
        .clk_clk         (clk),
        .reset_reset     (rst),
        .gpu_instruction (instr),
        .gpu_run         (run),
        .gpu_sprite      (spr),
        .gpu_ready       (gpu_ready),
        .vga_vsync       (vsync),
        .cmd             (cmd_if),
        .frame_swap      (frame_swap),
`ifdef GPU_CMD_STATS_EN
        .stat_cmds       (stat_cmds),
        .stat_frames     (stat_frames),
        .stat_overflow   (stat_overflow),
`endif
        .fifo_count      (fifo_count)
    );

    always #5 clk = ~clk;

    // kind: 0 sprite, 1 clear, 2 swap
    typedef struct {
        int         kind;
        logic [7:0] id;
        logic [9:0] x;
        logic [8:0] y;
        logic [4:0] flags;
        logic [7:0] color;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   hs_cnt = 0;
    int   swap_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected effect of one accepted push, straight from the word layout.
    task automatic model_push(input logic s, input logic [31:0] w);
        exp_t e;
        int   op;
        e = '{kind: 0, id: '0, x: '0, y: '0, flags: '0, color: '0};
        if (s) begin
            e.id    = 8'(w / 32'h0100_0000);
            e.x     = 10'((w / 16384) % 1024);
            e.y     = 9'((w / 32) % 512);
            e.flags = 5'(w % 32);
            q.push_back(e);
        end else begin
            op = int'(w / 32'h1000_0000);
            if (op == 1) begin
                e.kind  = 1;
                e.color = 8'(w % 256);
                q.push_back(e);
            end else if (op == 2) begin
                e.kind = 2;
                q.push_back(e);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic s, input logic [31:0] w, input bit acc);
        instr = w;
        spr   = s;
        run   = 1'b1;
        if (acc) model_push(s, w);
        tick(1);
        run = 1'b0;
        tick(1);
    endtask

    task automatic drain(input string tag, input int budget);
        int t;
        t = 0;
        cmd_if.cmd_ready = 1'b1;
        while ((q.size() != 0 || fifo_count != 0 || cmd_if.cmd_valid) && t < budget) begin
            if (t % 6 == 2) vsync = ~vsync;
            tick(1);
            t++;
        end
        chk(tag, 64'(t < budget), 64'd1);
        vsync = 1'b1;
        tick(2);
    endtask

    // Monitor: runs at negedge. Outputs reflect the last posedge; inputs are
    // the values the next posedge will sample.
    logic        vs_d1 = 1'b1, vs_d2 = 1'b1;
    logic        stall_d = 1'b0, rst_d = 1'b1;
    logic [63:0] stall_pl = '0;

    function automatic logic [63:0] payload();
        return 64'({cmd_if.cmd_op, cmd_if.cmd_sprite_id, cmd_if.cmd_x,
                    cmd_if.cmd_y, cmd_if.cmd_flags, cmd_if.cmd_color});
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_swap) begin
                swap_cnt++;
                chk("swap_after_vs_fall", 64'({vs_d2, vs_d1}), 64'b10);
                if (q.size() != 0 && q[0].kind == 2) void'(q.pop_front());
                else chk("swap_expected", 64'd0, 64'd1);
            end
            if (stall_d && !rst_d) begin
                chk("stall_valid", 64'(cmd_if.cmd_valid), 64'd1);
                chk("stall_payload", payload(), stall_pl);
            end
            if (!rst && cmd_if.cmd_valid && cmd_if.cmd_ready) begin
                hs_cnt++;
                if (q.size() == 0) begin
                    chk("hs_unexpected", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("hs_kind", 64'(cmd_if.cmd_op), 64'(e.kind));
                    if (e.kind == 0) begin
                        chk("hs_id", 64'(cmd_if.cmd_sprite_id), 64'(e.id));
                        chk("hs_x", 64'(cmd_if.cmd_x), 64'(e.x));
                        chk("hs_y", 64'(cmd_if.cmd_y), 64'(e.y));
                        chk("hs_flags", 64'(cmd_if.cmd_flags), 64'(e.flags));
                    end else if (e.kind == 1) begin
                        chk("hs_color", 64'(cmd_if.cmd_color), 64'(e.color));
                    end
                end
            end
            stall_d  = cmd_if.cmd_valid && !cmd_if.cmd_ready;
            stall_pl = payload();
            rst_d    = rst;
            vs_d2    = vs_d1;
            vs_d1    = vsync;
        end
    end

    initial begin
        int          hs0, sw0, k;
        logic [31:0] w;
        logic        s;
        cmd_if.cmd_ready = 1'b0;

        // Reset state
        tick(3);
        chk("rst_gpu_ready", 64'(gpu_ready), 64'd0);
        chk("rst_cmd_valid", 64'(cmd_if.cmd_valid), 64'd0);
        chk("rst_frame_swap", 64'(frame_swap), 64'd0);
        chk("rst_fifo_count", 64'(fifo_count), 64'd0);
        rst = 1'b0;
        tick(1);
        chk("ready_after_rst", 64'(gpu_ready), 64'd1);

        // 1. Sprite latency and decode
        instr = 32'h1232_0C83; spr = 1'b1; run = 1'b1;
        model_push(1'b1, 32'h1232_0C83);
        tick(1);
        run = 1'b0;
        chk("lat_k1_valid", 64'(cmd_if.cmd_valid), 64'd0);
        chk("lat_k1_count", 64'(fifo_count), 64'd1);
        tick(1);
        chk("lat_k2_valid", 64'(cmd_if.cmd_valid), 64'd1);
        chk("spr_op", 64'(cmd_if.cmd_op), 64'd0);
        chk("spr_id", 64'(cmd_if.cmd_sprite_id), 64'h12);
        chk("spr_x", 64'(cmd_if.cmd_x), 64'd200);
        chk("spr_y", 64'(cmd_if.cmd_y), 64'd100);
        chk("spr_flags", 64'(cmd_if.cmd_flags), 64'd3);

        // 2. Backpressure
        tick(10);
        chk("bp_valid_held", 64'(cmd_if.cmd_valid), 64'd1);
        hs0 = hs_cnt;
        cmd_if.cmd_ready = 1'b1;
        tick(1);
        cmd_if.cmd_ready = 1'b0;
        chk("bp_valid_drop", 64'(cmd_if.cmd_valid), 64'd0);
        tick(3);
        chk("bp_single_hs", 64'(hs_cnt - hs0), 64'd1);

        // 3. Overflow: park the FSM on a SWAP, then overfill
        push(1'b0, 32'h2000_0000, 1'b1);
        for (int i = 0; i < DEPTH; i++) push(1'b1, {8'(8'h40 + i), 24'($urandom)}, 1'b1);
        chk("ovf_ready_low", 64'(gpu_ready), 64'd0);
        chk("ovf_count_full", 64'(fifo_count), 64'd16);
        push(1'b1, 32'hFFFF_FFFF, 1'b0);
        chk("ovf_count_after", 64'(fifo_count), 64'd16);
        chk("ovf_ready_after", 64'(gpu_ready), 64'd0);
`ifdef GPU_CMD_STATS_EN
        chk("ovf_stat", 64'(stat_overflow), 64'd1);
`endif
        drain("ovf_drain", 400);

        // 4. Swap ordering
        cmd_if.cmd_ready = 1'b1;
        push(1'b0, 32'h1000_00E3, 1'b1);
        push(1'b0, 32'h2000_0000, 1'b1);
        push(1'b1, 32'h7F2C_8A45, 1'b1);
        sw0 = swap_cnt;
        tick(44);
        chk("swap_hold_count", 64'(fifo_count), 64'd1);
        chk("swap_hold_model", 64'(q.size()), 64'd2);
        chk("swap_not_early", 64'(swap_cnt - sw0), 64'd0);
        vsync = 1'b0;
        tick(1);
        chk("swap_pulse", 64'(frame_swap), 64'd1);
        tick(1);
        chk("swap_one_cycle", 64'(frame_swap), 64'd0);
        tick(4);
        vsync = 1'b1;
        chk("swap_count", 64'(swap_cnt - sw0), 64'd1);
        chk("swap_then_sprite", 64'(q.size()), 64'd0);

        // 5. Held run pushes once; NOP issues nothing
        cmd_if.cmd_ready = 1'b0;
        instr = 32'hAB00_0000; spr = 1'b1; run = 1'b1;
        model_push(1'b1, 32'hAB00_0000);
        tick(20);
        run = 1'b0;
        chk("held_count", 64'(fifo_count), 64'd0);
        chk("held_valid", 64'(cmd_if.cmd_valid), 64'd1);
        cmd_if.cmd_ready = 1'b1;
        tick(2);
        hs0 = hs_cnt;
        instr = 32'h0000_0000; spr = 1'b0; run = 1'b1;
        tick(20);
        run = 1'b0;
        tick(3);
        chk("nop_no_valid", 64'(cmd_if.cmd_valid), 64'd0);
        chk("nop_no_hs", 64'(hs_cnt - hs0), 64'd0);

        // 6. Reset mid-ISSUE and mid-WAIT_VS
        cmd_if.cmd_ready = 1'b0;
        push(1'b1, 32'h0102_0304, 1'b1);
        push(1'b0, 32'h1000_0055, 1'b1);
        chk("rst_issue_valid", 64'(cmd_if.cmd_valid), 64'd1);
        rst = 1'b1;
        q.delete();
        hs_cnt = 0; swap_cnt = 0;
        tick(1);
        chk("rst_mid_valid", 64'(cmd_if.cmd_valid), 64'd0);
        chk("rst_mid_count", 64'(fifo_count), 64'd0);
        chk("rst_mid_ready", 64'(gpu_ready), 64'd0);
        rst = 1'b0;
        tick(1);
        chk("rst_mid_ready_up", 64'(gpu_ready), 64'd1);
`ifdef GPU_CMD_STATS_EN
        chk("rst_stat_cmds", 64'(stat_cmds), 64'd0);
        chk("rst_stat_ovf", 64'(stat_overflow), 64'd0);
`endif
        push(1'b0, 32'h2000_0000, 1'b1);
        rst = 1'b1;
        q.delete();
        tick(1);
        vsync = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(4);
        vsync = 1'b1;
        tick(4);
        chk("rst_wait_no_swap", 64'(swap_cnt), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (run) begin
                run = 1'b0;
            end else if (gpu_ready && $urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, 7);
                w = $urandom;
                s = 1'b0;
                case (k)
                    0, 1, 2, 3: s = 1'b1;
                    4:          w = {4'h1, w[27:0]};
                    5:          w = {4'h2, w[27:0]};
                    6:          w = {4'h0, w[27:0]};
                    default:    w = {4'(3 + $urandom_range(0, 12)), w[27:0]};
                endcase
                instr = w; spr = s; run = 1'b1;
                model_push(s, w);
            end
            cmd_if.cmd_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) vsync = ~vsync;
            tick(1);
        end
        run = 1'b0;
        drain("rand_drain", 3000);
        chk("rand_model_empty", 64'(q.size()), 64'd0);
`ifdef GPU_CMD_STATS_EN
        chk("stat_cmds", 64'(stat_cmds), 64'(hs_cnt % 65536));
        chk("stat_frames", 64'(stat_frames), 64'(swap_cnt % 65536));
        chk("stat_no_ovf", 64'(stat_overflow), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
